// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle result pulses.
// Define UART_RX_PARITY_EN to expect an even-parity bit after D7 (11-bit frame).
module uart_rx #(
    parameter int BAUD_RATE = 9600,
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_TICK = CLK_FREQ / BAUD_RATE,
    parameter int HALF_TICK = BAUD_TICK / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_TICK - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_TICK - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        rx_meta;
    logic        rx_s;
    logic        parity_ok;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign parity_ok = ~(^{shift, par_bit});
`else
    assign parity_ok = 1'b1;
`endif

    // Whole receiver in one registered process; result pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            bit_idx    <= 3'd0;
            shift      <= 8'h00;
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            data       <= 8'h00;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        cnt     <= 16'd0;
                        bit_idx <= 3'd0;
                        busy    <= 1'b1;
                    end
                end

                // A start bit that is high again at its mid-point is treated as a glitch.
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= 16'd0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (cnt == BAUD_LAST) begin
                        cnt            <= 16'd0;
                        shift[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BAUD_LAST) begin
                        cnt     <= 16'd0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
`endif

                // A low stop bit wins over a parity mismatch and leaves data untouched.
                STOP: begin
                    if (cnt == BAUD_LAST) begin
                        cnt <= 16'd0;
                        if (rx_s) begin
                            data  <= shift;
                            busy  <= 1'b0;
                            state <= IDLE;
                            if (parity_ok) begin
                                valid <= 1'b1;
                            end else begin
                                parity_err <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                        cnt   <= 16'd0;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= 16'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit; define UART_RX_PARITY_EN for parity cases.
module tb_uart_rx;

    localparam int BT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    localparam logic [1:0] K_VALID = 2'd0;
    localparam logic [1:0] K_FRAME = 2'd1;
    localparam logic [1:0] K_PAR   = 2'd2;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    uart_rx #(.BAUD_RATE(1), .CLK_FREQ(16)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
        .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, actual, expected);
        end
    endtask

    task automatic driveBit(input logic b);
        rx = b;
        repeat (BT) @(posedge clk);
        #1;
    endtask

    task automatic idleClocks(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input logic par);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(b[i]);
`ifdef UART_RX_PARITY_EN
        driveBit(par);
`else
        if (par === 1'bx) $display("[TB] note: parity bit unused");
`endif
        driveBit(stop_bit);
    endtask

    task automatic expect_out(input logic [1:0] kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every result pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (valid || frame_err || parity_err)) begin
            logic [1:0] kind;
            exp_t       e;
            kind = (valid && !frame_err && !parity_err) ? K_VALID :
                   (frame_err && !valid && !parity_err) ? K_FRAME :
                   (parity_err && !valid && !frame_err) ? K_PAR : 2'd3;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got kind %0d data 0x%02h expected no pulse", kind, data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pulse_kind", {6'd0, kind}, {6'd0, e.kind});
                checkOutput("pulse_data", data, e.data);
                checkOutput("busy_at_pulse", {7'd0, busy}, (e.kind == K_FRAME) ? 8'd1 : 8'd0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_data", data, 8'h00);
        checkOutput("reset_valid", {7'd0, valid}, 8'd0);
        checkOutput("reset_frame_err", {7'd0, frame_err}, 8'd0);
        checkOutput("reset_parity_err", {7'd0, parity_err}, 8'd0);
        checkOutput("reset_busy", {7'd0, busy}, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idleClocks(2 * BT);

        // Single good byte
        expect_out(K_VALID, 8'hA5);
        applyStimulus(8'hA5, 1'b1, ^8'hA5);
        idleClocks(20);
        checkOutput("busy_after_a5", {7'd0, busy}, 8'd0);

        // Back-to-back frames with exactly one stop bit
        expect_out(K_VALID, 8'h00);
        expect_out(K_VALID, 8'hFF);
        applyStimulus(8'h00, 1'b1, ^8'h00);
        applyStimulus(8'hFF, 1'b1, ^8'hFF);
        idleClocks(20);

        // Start-bit glitch of 3 clocks
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        @(negedge clk);
        checkOutput("glitch_busy_high", {7'd0, busy}, 8'd1);
        idleClocks(20);
        checkOutput("glitch_busy_low", {7'd0, busy}, 8'd0);
        checkOutput("glitch_data_kept", data, 8'hFF);

        // Framing error followed by a 40-clock break
        expect_out(K_FRAME, 8'hFF);
        applyStimulus(8'h3C, 1'b0, ^8'h3C);
        rx = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        checkOutput("break_busy", {7'd0, busy}, 8'd1);
        checkOutput("break_data_kept", data, 8'hFF);
        idleClocks(6);
        checkOutput("break_release_busy", {7'd0, busy}, 8'd0);
        idleClocks(BT);
        expect_out(K_VALID, 8'h12);
        applyStimulus(8'h12, 1'b1, ^8'h12);
        idleClocks(20);

        // Reset during bit 4 of 0x5A
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(8'h5A >> i);
        rx = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", {7'd0, busy}, 8'd0);
        checkOutput("abort_data", data, 8'h00);
        idleClocks(2 * BT);
        expect_out(K_VALID, 8'h81);
        applyStimulus(8'h81, 1'b1, ^8'h81);
        idleClocks(20);

`ifdef UART_RX_PARITY_EN
        expect_out(K_VALID, 8'h07);
        applyStimulus(8'h07, 1'b1, 1'b1);
        idleClocks(20);
        expect_out(K_PAR, 8'h07);
        applyStimulus(8'h07, 1'b1, 1'b0);
        idleClocks(20);
        checkOutput("parity_err_data", data, 8'h07);
`endif

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
